// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC and issues single-outstanding SRAM-like
// instruction reads, presenting each completed fetch to the IF/ID register.
module inst_fetch_ctrl #(
  parameter logic [31:0] PC_INIT  = 32'hBFC0_0000,
  parameter logic [4:0]  EXC_NONE = 5'h10,
  parameter logic [4:0]  EXC_ADEL = 5'h04,
  parameter int          STALL_W  = 6
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  input  logic               jump_flag,
  input  logic [31:0]        jump_addr,
  output logic               inst_req,
  output logic               inst_wr,
  output logic [1:0]         inst_size,
  output logic [31:0]        inst_addr,
  input  logic               inst_addr_ok,
  input  logic [31:0]        inst_rdata,
  input  logic               inst_data_ok,
  output logic               stallreq_if,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus_4,
  output logic [4:0]         if_exccode,
  output logic               if_inst_data_ok,
  output logic [31:0]        if_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        pend_jmp_reg, pend_jmp_next;
  logic [31:0] jmp_tgt_reg, jmp_tgt_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [4:0]  buf_exc_reg, buf_exc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;

  logic        if_stalled;
  logic        pc_aligned;
  logic        complete;
  logic        holding;
  logic        advance;
  logic [31:0] next_pc;

  logic        req_c;
  logic        valid_c;
  logic [31:0] pc_c;
  logic [4:0]  exc_c;
  logic [31:0] inst_c;

  // Only stall[1] concerns the IF stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[STALL_W-1:2], stall[0]};

  assign if_stalled = stall[1];
  assign pc_aligned = (pc_reg[1:0] == 2'b00);

  // A taken branch this cycle wins over a target remembered across the delay slot.
  assign next_pc = jump_flag    ? jump_addr   :
                   pend_jmp_reg ? jmp_tgt_reg :
                                  pc_reg + 32'd4;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_reg    <= S_REQ;
      pc_reg       <= PC_INIT;
      pend_jmp_reg <= 1'b0;
      jmp_tgt_reg  <= 32'd0;
      buf_pc_reg   <= PC_INIT;
      buf_exc_reg  <= EXC_NONE;
      buf_inst_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pend_jmp_reg <= pend_jmp_next;
      jmp_tgt_reg  <= jmp_tgt_next;
      buf_pc_reg   <= buf_pc_next;
      buf_exc_reg  <= buf_exc_next;
      buf_inst_reg <= buf_inst_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pend_jmp_next = pend_jmp_reg;
    jmp_tgt_next  = jmp_tgt_reg;
    buf_pc_next   = buf_pc_reg;
    buf_exc_next  = buf_exc_reg;
    buf_inst_next = buf_inst_reg;
    complete      = 1'b0;
    holding       = 1'b0;
    req_c         = 1'b0;
    valid_c       = 1'b0;
    pc_c          = pc_reg;
    exc_c         = EXC_NONE;
    inst_c        = 32'd0;

    case (state_reg)
      S_REQ: begin
        req_c = pc_aligned;
        if (!pc_aligned) begin
          // Misaligned PC never reaches the bus; it completes as an exception.
          complete = 1'b1;
          exc_c    = EXC_ADEL;
        end else if (inst_addr_ok) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          complete = 1'b1;
          inst_c   = inst_rdata;
        end
      end
      S_HOLD: begin
        holding = 1'b1;
        valid_c = 1'b1;
        pc_c    = buf_pc_reg;
        exc_c   = buf_exc_reg;
        inst_c  = buf_inst_reg;
      end
      S_DROP: begin
        if (inst_data_ok) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase

    advance = (complete | holding) & ~if_stalled;

    if (complete) begin
      valid_c = 1'b1;
      if (if_stalled) begin
        buf_pc_next   = pc_reg;
        buf_exc_next  = exc_c;
        buf_inst_next = inst_c;
        state_next    = S_HOLD;
      end
    end

    if (advance) begin
      pc_next       = next_pc;
      pend_jmp_next = 1'b0;
      state_next    = S_REQ;
    end else if (jump_flag) begin
      // Delay slot not yet taken: remember the target until it completes.
      jmp_tgt_next  = jump_addr;
      pend_jmp_next = 1'b1;
    end

    if (flush) begin
      pc_next       = flush_pc;
      pend_jmp_next = 1'b0;
      valid_c       = 1'b0;
      if ((state_reg == S_WAIT && !inst_data_ok) ||
          (state_reg == S_REQ && pc_aligned && inst_addr_ok) ||
          (state_reg == S_DROP && !inst_data_ok)) begin
        state_next = S_DROP;
      end else begin
        state_next = S_REQ;
      end
    end
  end

  assign inst_wr   = 1'b0;
  assign inst_size = 2'b10;
  assign inst_addr = pc_reg;

  assign inst_req        = ~cpu_rst & req_c;
  assign if_inst_data_ok = ~cpu_rst & valid_c;
  assign if_pc           = cpu_rst ? PC_INIT  : pc_c;
  assign if_exccode      = cpu_rst ? EXC_NONE : exc_c;
  assign if_inst         = cpu_rst ? 32'd0    : inst_c;
  assign if_pc_plus_4    = if_pc + 32'd4;

  assign stallreq_if = ~cpu_rst & (((state_reg == S_WAIT) & ~inst_data_ok) |
                                   ((state_reg == S_REQ) & pc_aligned) |
                                   (state_reg == S_DROP));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: fetch, stall hold, delay-slot branch,
// flush discard, misaligned fetch and a slow address handshake.
module tb_inst_fetch_ctrl;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        stallreq_if;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [4:0]  if_exccode;
  logic        if_inst_data_ok;
  logic [31:0] if_inst;

  int n_cmp = 0;
  int n_err = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  inst_fetch_ctrl dut (
    .cpu_clk_50M    (cpu_clk_50M),
    .cpu_rst        (cpu_rst),
    .stall          (stall),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .jump_flag      (jump_flag),
    .jump_addr      (jump_addr),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_data_ok   (inst_data_ok),
    .stallreq_if    (stallreq_if),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_exccode     (if_exccode),
    .if_inst_data_ok(if_inst_data_ok),
    .if_inst        (if_inst)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 5 ns later.
  task automatic next_cyc();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic drive(input logic aok, input logic dok, input logic [31:0] rd);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
  endtask

  initial begin
    cpu_rst   = 1'b1;
    stall     = 6'd0;
    flush     = 1'b0;
    flush_pc  = 32'd0;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    drive(1'b0, 1'b0, 32'hDEAD_BEEF);

    next_cyc();
    next_cyc();
    settle();
    chk_eq("rst_req",    {31'd0, inst_req}, 32'd0);
    chk_eq("rst_valid",  {31'd0, if_inst_data_ok}, 32'd0);
    chk_eq("rst_stallq", {31'd0, stallreq_if}, 32'd0);
    chk_eq("rst_pc",     if_pc, 32'hBFC0_0000);
    chk_eq("rst_pc4",    if_pc_plus_4, 32'hBFC0_0004);
    chk_eq("rst_exc",    {27'd0, if_exccode}, 32'h10);
    chk_eq("rst_inst",   if_inst, 32'd0);
    chk_eq("const_wr",   {31'd0, inst_wr}, 32'd0);
    chk_eq("const_size", {30'd0, inst_size}, 32'd2);

    // Basic fetch: accept now, data two cycles later.
    next_cyc();
    cpu_rst = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("f0_req",    {31'd0, inst_req}, 32'd1);
    chk_eq("f0_addr",   inst_addr, 32'hBFC0_0000);
    chk_eq("f0_stallq", {31'd0, stallreq_if}, 32'd1);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0);
    settle();
    chk_eq("f0_wait_req",   {31'd0, inst_req}, 32'd0);
    chk_eq("f0_wait_valid", {31'd0, if_inst_data_ok}, 32'd0);
    chk_eq("f0_wait_stall", {31'd0, stallreq_if}, 32'd1);
    next_cyc();
    drive(1'b0, 1'b1, 32'h2408_0001);
    settle();
    chk_eq("f0_valid",  {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("f0_inst",   if_inst, 32'h2408_0001);
    chk_eq("f0_pc",     if_pc, 32'hBFC0_0000);
    chk_eq("f0_pc4",    if_pc_plus_4, 32'hBFC0_0004);
    chk_eq("f0_exc",    {27'd0, if_exccode}, 32'h10);
    chk_eq("f0_stallq", {31'd0, stallreq_if}, 32'd0);

    // Second fetch completes under IF stall and is held for three stalled cycles.
    next_cyc();
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("f1_req",  {31'd0, inst_req}, 32'd1);
    chk_eq("f1_addr", inst_addr, 32'hBFC0_0004);
    next_cyc();
    drive(1'b0, 1'b1, 32'h3C1D_BFC0);
    stall = 6'b000010;
    settle();
    chk_eq("f1_valid", {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("f1_inst",  if_inst, 32'h3C1D_BFC0);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      drive(1'b0, 1'b0, 32'h1111_1111);
      settle();
      chk_eq("hold_valid",  {31'd0, if_inst_data_ok}, 32'd1);
      chk_eq("hold_inst",   if_inst, 32'h3C1D_BFC0);
      chk_eq("hold_pc",     if_pc, 32'hBFC0_0004);
      chk_eq("hold_req",    {31'd0, inst_req}, 32'd0);
      chk_eq("hold_stallq", {31'd0, stallreq_if}, 32'd0);
    end
    next_cyc();
    stall = 6'd0;
    settle();
    chk_eq("unhold_valid", {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("unhold_inst",  if_inst, 32'h3C1D_BFC0);

    // Delay slot at BFC00008 in flight when the branch resolves.
    next_cyc();
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("ds_addr", inst_addr, 32'hBFC0_0008);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0);
    jump_flag = 1'b1;
    jump_addr = 32'hBFC0_0100;
    settle();
    chk_eq("ds_wait_valid", {31'd0, if_inst_data_ok}, 32'd0);
    next_cyc();
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    drive(1'b0, 1'b1, 32'h0000_0000);
    settle();
    chk_eq("ds_valid", {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("ds_pc",    if_pc, 32'hBFC0_0008);
    next_cyc();
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("br_req",  {31'd0, inst_req}, 32'd1);
    chk_eq("br_addr", inst_addr, 32'hBFC0_0100);

    // Flush while waiting: the stale response must be swallowed.
    next_cyc();
    drive(1'b0, 1'b0, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'hBFC0_0380;
    settle();
    chk_eq("fl_valid", {31'd0, if_inst_data_ok}, 32'd0);
    next_cyc();
    flush = 1'b0;
    settle();
    chk_eq("drop_req",    {31'd0, inst_req}, 32'd0);
    chk_eq("drop_stallq", {31'd0, stallreq_if}, 32'd1);
    next_cyc();
    drive(1'b0, 1'b1, 32'hBAD0_BAD0);
    settle();
    chk_eq("drop_valid", {31'd0, if_inst_data_ok}, 32'd0);
    chk_eq("drop_req2",  {31'd0, inst_req}, 32'd0);
    next_cyc();
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("fl_req",  {31'd0, inst_req}, 32'd1);
    chk_eq("fl_addr", inst_addr, 32'hBFC0_0380);

    // Completion with a same-cycle jump to a misaligned target.
    next_cyc();
    drive(1'b0, 1'b1, 32'h0000_000C);
    jump_flag = 1'b1;
    jump_addr = 32'h8000_0002;
    settle();
    chk_eq("j_valid", {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("j_pc",    if_pc, 32'hBFC0_0380);
    next_cyc();
    drive(1'b0, 1'b0, 32'h5555_AAAA);
    jump_addr = 32'hFFFF_FFFC;
    settle();
    chk_eq("adel_req",    {31'd0, inst_req}, 32'd0);
    chk_eq("adel_valid",  {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("adel_exc",    {27'd0, if_exccode}, 32'h04);
    chk_eq("adel_inst",   if_inst, 32'd0);
    chk_eq("adel_pc",     if_pc, 32'h8000_0002);
    chk_eq("adel_stallq", {31'd0, stallreq_if}, 32'd0);

    // Address handshake refused for five cycles.
    next_cyc();
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      settle();
      chk_eq("slow_req",    {31'd0, inst_req}, 32'd1);
      chk_eq("slow_addr",   inst_addr, 32'hFFFF_FFFC);
      chk_eq("slow_stallq", {31'd0, stallreq_if}, 32'd1);
      chk_eq("slow_valid",  {31'd0, if_inst_data_ok}, 32'd0);
      next_cyc();
    end
    drive(1'b1, 1'b0, 32'd0);
    settle();
    chk_eq("slow_acc_req", {31'd0, inst_req}, 32'd1);
    next_cyc();
    drive(1'b0, 1'b1, 32'h1234_5678);
    settle();
    chk_eq("wrap_valid", {31'd0, if_inst_data_ok}, 32'd1);
    chk_eq("wrap_inst",  if_inst, 32'h1234_5678);
    chk_eq("wrap_pc4",   if_pc_plus_4, 32'h0000_0000);
    next_cyc();
    drive(1'b0, 1'b0, 32'd0);
    settle();
    chk_eq("wrap_next", inst_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
